// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of the shared 32-bit ALU: grants one requester at a time,
// registers its operands onto the ALU, waits ALU_LAT cycles and returns RESULT/ZERO.
module alu_arbiter #(
  parameter int unsigned ALU_LAT    = 1,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VALID0,
  input  logic        VALID1,
  input  logic [31:0] DATA1_0,
  input  logic [31:0] DATA1_1,
  input  logic [31:0] DATA2_0,
  input  logic [31:0] DATA2_1,
  input  logic [2:0]  SELECT0,
  input  logic [2:0]  SELECT1,
  input  logic        ROTATE0,
  input  logic        ROTATE1,
  output logic        READY0,
  output logic        READY1,
  output logic        RSP_VALID0,
  output logic        RSP_VALID1,
  input  logic        RSP_READY0,
  input  logic        RSP_READY1,
  output logic [31:0] RESULT_OUT,
  output logic        ZERO_OUT,
  output logic [31:0] ALU_DATA1,
  output logic [31:0] ALU_DATA2,
  output logic [2:0]  ALU_SELECT,
  output logic        ALU_ROTATE,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_ZERO,
  output logic        BUSY,
  output logic        OWNER
);

  localparam int unsigned WaitW   = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WaitW-1:0]   WaitInit  = WaitW'(ALU_LAT - 1);
  localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [StarveW-1:0]   starve_q, starve_d;
  logic [WaitW-1:0]     wait_q, wait_d;
  logic [31:0]          alu_data1_q, alu_data1_d;
  logic [31:0]          alu_data2_q, alu_data2_d;
  logic [2:0]           alu_select_q, alu_select_d;
  logic                 alu_rotate_q, alu_rotate_d;
  logic [31:0]          result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 owner_q, owner_d;

  logic grant;
  logic starve_force;
  logic accept;
  logic rsp_taken;

  // Grant is purely combinational from the valids; the FSM only acts on it in IDLE.
  always_comb begin
    starve_force = (STARVE_MAX != 0) && (starve_q == StarveTop);
    if (FIXED_PRIO != 0) begin
      grant = VALID1 && (!VALID0 || starve_force);
    end else if (VALID0 && VALID1) begin
      grant = ~last_grant_q;
    end else begin
      grant = VALID1;
    end
    accept    = (state_q == StIdle) && (grant ? VALID1 : VALID0);
    rsp_taken = owner_q ? RSP_READY1 : RSP_READY0;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    starve_d     = starve_q;
    wait_d       = wait_q;
    alu_data1_d  = alu_data1_q;
    alu_data2_d  = alu_data2_q;
    alu_select_d = alu_select_q;
    alu_rotate_d = alu_rotate_q;
    result_d     = result_q;
    zero_d       = zero_q;
    owner_d      = owner_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          alu_data1_d  = grant ? DATA1_1 : DATA1_0;
          alu_data2_d  = grant ? DATA2_1 : DATA2_0;
          alu_select_d = grant ? SELECT1 : SELECT0;
          alu_rotate_d = grant ? ROTATE1 : ROTATE0;
          owner_d      = grant;
          last_grant_d = grant;
          wait_d       = WaitInit;
          state_d      = StExec;
          // Count port-0 wins only while port 1 is actually waiting.
          if (grant) begin
            starve_d = '0;
          end else if (VALID1 && (starve_q != StarveTop)) begin
            starve_d = starve_q + 1'b1;
          end
        end
      end
      StExec: begin
        if (wait_q == '0) begin
          result_d = ALU_RESULT;
          zero_d   = ALU_ZERO;
          state_d  = StResp;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_taken) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      starve_q     <= '0;
      wait_q       <= '0;
      alu_data1_q  <= '0;
      alu_data2_q  <= '0;
      alu_select_q <= '0;
      alu_rotate_q <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      starve_q     <= starve_d;
      wait_q       <= wait_d;
      alu_data1_q  <= alu_data1_d;
      alu_data2_q  <= alu_data2_d;
      alu_select_q <= alu_select_d;
      alu_rotate_q <= alu_rotate_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      owner_q      <= owner_d;
    end
  end

  assign READY0     = accept && !grant;
  assign READY1     = accept && grant;
  assign RSP_VALID0 = (state_q == StResp) && !owner_q;
  assign RSP_VALID1 = (state_q == StResp) && owner_q;
  assign RESULT_OUT = result_q;
  assign ZERO_OUT   = zero_q;
  assign ALU_DATA1  = alu_data1_q;
  assign ALU_DATA2  = alu_data2_q;
  assign ALU_SELECT = alu_select_q;
  assign ALU_ROTATE = alu_rotate_q;
  assign BUSY       = (state_q != StIdle);
  assign OWNER      = owner_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 32-bit integer ALU between two requesters: port 0 is the pipeline execute stage and port 1 is the context-switch/cache-switch engine. It arbitrates requests, registers the winning operands onto the ALU inputs, and waits a fixed number of cycles. It then captures RESULT/ZERO and returns them to the owning requester over a valid/ready response channel. One operation is in flight at a time.

Parameters:
ALU_LAT, 1, cycles the operands are held on the ALU before the result is sampled (legal values are 1 and above).
FIXED_PRIO, 0, 0 selects round-robin; 1 selects fixed priority to port 0.
STARVE_MAX, 4, fixed-priority mode only: number of consecutive port-0 grants made while port 1 waits before port 1 is forced a grant (0 disables the override).

Ports:
CLK  in  1  clock; all state changes on its rising edge
RESET  in  1  synchronous, active-high reset
VALID0, VALID1  in  1 each  request valid
DATA1_0, DATA1_1  in  32 each  operand 1
DATA2_0, DATA2_1  in  32 each  operand 2
SELECT0, SELECT1  in  3 each  ALU opcode, passed through unmodified (0 pass DATA2, 1 add, 2 and, 3 or, 4 xor, 5 xnor, 6 shift right, 7 shift left)
ROTATE0, ROTATE1  in  1 each  shift-type bit, passed through
READY0, READY1  out  1 each  request accepted this cycle
RSP_VALID0, RSP_VALID1  out  1 each  response valid
RSP_READY0, RSP_READY1  in  1 each  requester takes the response
RESULT_OUT  out  32  captured ALU result, shared by both ports
ZERO_OUT  out  1  captured ALU ZERO (DATA1==DATA2)
ALU_DATA1, ALU_DATA2  out  32 each  registered operands to the ALU
ALU_SELECT  out  3  registered opcode to the ALU
ALU_ROTATE  out  1  registered shift-type bit to the ALU
ALU_RESULT  in  32  ALU RESULT
ALU_ZERO  in  1  ALU ZERO
BUSY  out  1  high whenever the state is not IDLE
OWNER  out  1  port owning the current operation

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (synchronous, active-high):
  - state goes to IDLE; LAST_GRANT=1 (port 0 wins first); starvation counter=0; wait counter=0.
  - All outputs are 0: ALU_* regs, RESULT_OUT, ZERO_OUT, OWNER, RSP_VALIDx, BUSY.
  - Reset asserted in EXEC or RESP abandons the operation. No response is issued, and the abandoned op is not replayed.
- IDLE:
  - GRANT is combinational from VALID0/VALID1. READYx = (state==IDLE) && GRANT==x && VALIDx. At most one READY is high.
  - Round-robin: if both ports are valid, grant the port != LAST_GRANT. If one port is valid, grant it.
  - Fixed priority: port 0 wins unless port 1 is valid and the starvation counter == STARVE_MAX (STARVE_MAX != 0).
  - Starvation counter: increments on a port-0 grant while VALID1 is high, clears on a port-1 grant, saturates at STARVE_MAX.
  - On handshake: latch operands into ALU_* regs, set OWNER and LAST_GRANT, load wait counter with ALU_LAT-1, go to EXEC.
- EXEC:
  - ALU_* held stable. Wait counter decrements each cycle.
  - In the cycle the counter is 0: capture ALU_RESULT into RESULT_OUT and ALU_ZERO into ZERO_OUT at the edge, go to RESP.
- RESP:
  - RSP_VALID[OWNER]=1; RESULT_OUT/ZERO_OUT held.
  - When RSP_READY[OWNER]=1: at the edge clear RSP_VALID and go to IDLE.
  - RSP_READY on the non-owner port is ignored.
- Timing:
  - Request accepted at edge t → RSP_VALID high from edge t+ALU_LAT.
  - Minimum spacing between accepts is ALU_LAT+2 cycles (no IDLE bypass).
- ALU_* hold their last values in IDLE; operands toggle only on a grant.
- Requester protocol: payload must be stable while VALID is high and READY is low. VALID dropped before the handshake causes no state change.
- VALIDx and RSP_READYx may be high together. A new request from the owner is only accepted after returning to IDLE.
- No arithmetic is done in this block. Widths are passed through unchanged.

Test Plan:
- Single op, round-robin, ALU_LAT=1: port0 VALID with DATA1=5, DATA2=7, SELECT=1 → READY0 in the same cycle; RSP_VALID0 one edge later; RESULT_OUT=12, ZERO_OUT=0; RSP_VALID1 stays 0.
- Both ports valid every cycle, RSP_READY tied high → grants alternate 0,1,0,1 starting with port 0; each RESULT_OUT matches its owner's op (port1 XOR 0xF0F0F0F0^0x0F0F0F0F = 0xFFFFFFFF).
- Backpressure: RSP_READY0=0 for 5 cycles after RSP_VALID0 → RESULT_OUT, ZERO_OUT and RSP_VALID0 held stable; no READY to either port until the response is taken.
- FIXED_PRIO=1, STARVE_MAX=4, both valid continuously → four port-0 grants, then one port-1 grant, then the counter clears and the pattern repeats.
- ALU_LAT=3: port1 DATA1=DATA2=0x1234, SELECT=0 → RSP_VALID1 3 edges after accept, RESULT_OUT=0x1234, ZERO_OUT=1; ALU_* stable for all 3 EXEC cycles.
- RESET pulsed during EXEC → next cycle state is IDLE, all outputs 0, no RSP_VALID; a subsequent port-0 request is granted first and completes normally.
